rom_download_packer: RTL

//  Sits between data_io and the SDRAM ROM-load port inside the core top.

---
 rtl/rom_download_packer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/rom_download_packer.sv
// rom_download_packer
// Packs the ioctl byte stream for one download index into 16-bit big-endian
// words. Words are queued in a small FIFO and written out through a toggle
// req/ack SDRAM port. rom_loaded is raised once the download window has closed
// and every word has been written.
module rom_download_packer #(
    parameter logic [7:0] ROM_INDEX = 8'd0,
    parameter int         FIFO_AW   = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        sdram_req,
    input  logic        sdram_ack,
    output logic [23:0] sdram_addr,
    output logic [15:0] sdram_dout,
    output logic        busy,
    output logic        rom_loaded,
    output logic        overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_W = (FIFO_AW + 1)'(DEPTH);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    // FIFO storage: each entry is {word address, word data}
    logic [39:0] fifo_mem_q [DEPTH];

    logic               dl_prev_q,  dl_prev_d;
    logic [7:0]         hi_data_q,  hi_data_d;
    logic [23:0]        hi_addr_q,  hi_addr_d;
    logic               hi_valid_q, hi_valid_d;
    logic [FIFO_AW:0]   wr_ptr_q,   wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q,   rd_ptr_d;
    logic               state_q,    state_d;
    logic               req_q,      req_d;
    logic [23:0]        addr_out_q, addr_out_d;
    logic [15:0]        dout_out_q, dout_out_d;
    logic               overflow_q, overflow_d;
    logic               end_seen_q, end_seen_d;
    logic               loaded_q,   loaded_d;

    logic               dl_rise;
    logic               dl_fall;
    logic               accept;
    logic               latch_valid_eff;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push_req;
    logic               push_en;
    logic [39:0]        push_word;
    logic [39:0]        head_word;

    assign dl_rise    = ioctl_download & ~dl_prev_q;
    assign dl_fall    = ~ioctl_download & dl_prev_q;
    assign accept     = ioctl_download & ioctl_wr & (ioctl_index == ROM_INDEX);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == DEPTH_W);
    assign pop        = (state_q == ST_WAIT) && (sdram_ack == req_q);
    assign head_word  = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
    // A download restart discards any half-assembled word
    assign latch_valid_eff = hi_valid_q & ~dl_rise;

    assign busy       = (state_q != ST_IDLE) | ~fifo_empty;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_out_q;
    assign sdram_dout = dout_out_q;
    assign rom_loaded = loaded_q;
    assign overflow   = overflow_q;

    // Next-state: byte packing, FIFO pointers, writer FSM and status flags
    always_comb begin
        dl_prev_d  = ioctl_download;
        hi_data_d  = hi_data_q;
        hi_addr_d  = hi_addr_q;
        hi_valid_d = hi_valid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        state_d    = state_q;
        req_d      = req_q;
        addr_out_d = addr_out_q;
        dout_out_d = dout_out_q;
        overflow_d = overflow_q;
        end_seen_d = end_seen_q;
        loaded_d   = loaded_q;
        push_req   = 1'b0;
        push_en    = 1'b0;
        push_word  = 40'd0;

        if (dl_rise) begin
            overflow_d = 1'b0;
            end_seen_d = 1'b0;
            hi_valid_d = 1'b0;
        end

        // Flush a dangling even byte when the window closes; pad low byte
        if (dl_fall) begin
            end_seen_d = 1'b1;
            hi_valid_d = 1'b0;
            if (hi_valid_q) begin
                push_req  = 1'b1;
                push_word = {hi_addr_q, hi_data_q, 8'hFF};
            end
        end

        if (accept) begin
            if (!ioctl_addr[0]) begin
                hi_data_d  = ioctl_dout;
                hi_addr_d  = ioctl_addr[24:1];
                hi_valid_d = 1'b1;
            end else begin
                push_req   = 1'b1;
                push_word  = {ioctl_addr[24:1],
                              (latch_valid_eff ? hi_data_q : 8'hFF),
                              ioctl_dout};
                hi_valid_d = 1'b0;
            end
        end

        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        if (push_req) begin
            if (fifo_full && !pop) begin
                overflow_d = 1'b1;
            end else begin
                push_en  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    addr_out_d = head_word[39:16];
                    dout_out_d = head_word[15:0];
                    req_d      = ~req_q;
                    state_d    = ST_WAIT;
                end
            end
            default: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
        endcase

        if (dl_rise) begin
            loaded_d = 1'b0;
        end else if (end_seen_q && !busy && !hi_valid_q && !ioctl_download) begin
            loaded_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_prev_q  <= 1'b0;
            hi_data_q  <= 8'd0;
            hi_addr_q  <= 24'd0;
            hi_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_out_q <= 24'd0;
            dout_out_q <= 16'd0;
            overflow_q <= 1'b0;
            end_seen_q <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            dl_prev_q  <= dl_prev_d;
            hi_data_q  <= hi_data_d;
            hi_addr_q  <= hi_addr_d;
            hi_valid_q <= hi_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            req_q      <= req_d;
            addr_out_q <= addr_out_d;
            dout_out_q <= dout_out_d;
            overflow_q <= overflow_d;
            end_seen_q <= end_seen_d;
            loaded_q   <= loaded_d;
        end
    end

    // FIFO storage write; contents need no reset since pointers gate reads
    always_ff @(posedge clk_sys) begin
        if (push_en) begin
            fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_word;
        end
    end

endmodule
